mem_arbiter19: RTL and testbench
================================

# mem_arbiter19

Single-ported 1024 x 19 unified memory with an access arbiter for the 19-bit pipelined CPU. It shares the memory between three requesters:
- the loader/debug port (L), which fills programs and reads results;
- the instruction-fetch port (I);
- the data port (D), used for LW/SW.

Each cycle at most one access is accepted. L has fixed priority, with a starvation guard. I and D alternate round-robin. Read data returns one cycle after grant.

## Interface
Parameters:
- DW, 19, data/instruction word width
- AW, 10, address width; depth = 2**AW words
- STARVE_LIMIT, 4, max consecutive cycles L may block a pending I/D request (1..15)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- l_req, i_req, d_req  in  1 each  access request; held until granted
- l_we, d_we  in  1 each  1 = write, 0 = read (I is read-only)
- l_addr, i_addr, d_addr  in  AW each  word address
- l_wdata, d_wdata  in  DW each  write data
- l_gnt, i_gnt, d_gnt  out  1 each  combinational grant, one-hot or all zero
- l_rvalid, i_rvalid, d_rvalid  out  1 each  registered read-data valid, one cycle after a read grant
- rdata  out  DW  shared registered read data, qualified by the *_rvalid strobes

## Operation
- Requester protocol: assert req together with we/addr/wdata. Hold them stable until the cycle gnt=1. The access occurs at the rising edge that ends the grant cycle. Deassert req the following cycle or issue the next access.
- Grant is combinational from req, rr_ptr and starve_cnt. It is a function of current inputs and state only, with no loops through gnt.
- Priority:
  - If l_req=1 and not (starve_cnt==STARVE_LIMIT and (i_req or d_req)), grant L.
  - Otherwise, if both i_req and d_req are 1, grant the port selected by rr_ptr (0=I, 1=D).
  - Otherwise, grant whichever of i_req/d_req is 1.
  - With no requests, no grant.
- rr_ptr updates only when I or D is granted: on an I grant it becomes 1, on a D grant it becomes 0. A lone requester is granted regardless of rr_ptr and still updates it.
- starve_cnt (4-bit):
  - Increments when L is granted while i_req or d_req is 1.
  - Clears to 0 when I or D is granted.
  - Clears to 0 when no I/D request is pending.
  - Otherwise holds.
  - Never exceeds STARVE_LIMIT.
- Write (we=1 on a granted L/D access): mem[addr] <= wdata at the grant edge. No rvalid is generated for writes.
- Read: at the grant edge, rdata <= mem[addr] and the granter's rvalid <= 1. In every other cycle all rvalid are 0 and rdata holds its last value.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data.
- Memory contents are not reset; the loader initialises them.
- Reset values: rdata=0, all rvalid=0, rr_ptr=0 (I favoured first), starve_cnt=0. All gnt=0 while rst=1, regardless of req.
- Reset mid-operation: any access whose grant edge coincides with rst=1 is dropped (no write, no rvalid). A held request is re-arbitrated after rst falls.

## Timing
- Grant latency: same cycle as req when uncontested.
- Read latency: rvalid and rdata one cycle after the grant cycle.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed.
- Worst-case I/D wait under continuous L traffic: STARVE_LIMIT cycles.
- Worst-case I wait with D also requesting: 1 extra cycle (round-robin), plus any L grants.
- Simultaneous events:
  - The starvation override and an L request in the same cycle resolve to the I/D grant.
  - rst deasserting and req asserting in the same cycle grant normally.

## Test plan
- Loader fill: L writes 19'h2801a..19'h2801f to addresses 0..5 on consecutive cycles, then reads address 3. Expect l_gnt=1 each cycle, then l_rvalid=1 with rdata=19'h2801d one cycle after the read grant.
- Round-robin: mem[0]=19'h0ce77 and mem[40]=19'h00123; I reads addr 0 and D reads addr 40 every cycle with both held high after reset. Expect grants I,D,I,D…, with rdata alternating 19'h0ce77 / 19'h00123 one cycle later.
- Starvation guard (STARVE_LIMIT=4): L and I request continuously. Expect the grant pattern L,L,L,L,I,L,L,L,L,I…; starve_cnt never exceeds 4.
- Read-after-write: D writes 19'h7ffff to addr 1023, then I reads addr 1023 on the next cycle. Expect i_rvalid=1 with rdata=19'h7ffff; a D read of addr 0 returns pre-existing data, proving no address wrap corruption.
- Reset mid-operation: assert rst during a granted D write of 19'h12345 to addr 7 (old value 19'h00007). Expect gnt=0 and rvalid=0 immediately. After release, mem[7] still reads 19'h00007, and rr_ptr=0, so I wins the first contested cycle.

Source files
------------

// File: rtl/mem_arbiter19.sv
// mem_arbiter19: single-ported 1024 x 19 unified memory shared by the loader (L),
// instruction-fetch (I) and data (D) ports. L has fixed priority with a starvation
// guard, I and D alternate round-robin, and read data returns one cycle after grant.
module mem_arbiter19 #(
    parameter int DW           = 19,
    parameter int AW           = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          l_req,
    input  logic          i_req,
    input  logic          d_req,
    input  logic          l_we,
    input  logic          d_we,
    input  logic [AW-1:0] l_addr,
    input  logic [AW-1:0] i_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic [DW-1:0] d_wdata,
    output logic          l_gnt,
    output logic          i_gnt,
    output logic          d_gnt,
    output logic          l_rvalid,
    output logic          i_rvalid,
    output logic          d_rvalid,
    output logic [DW-1:0] rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [DW-1:0] mem [2**AW];

    logic          rr_ptr_q, rr_ptr_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          l_rvalid_q, l_rvalid_d;
    logic          i_rvalid_q, i_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          id_pending;
    logic          starve_hit;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] wr_data;

    assign id_pending = i_req | d_req;
    assign starve_hit = (starve_cnt_q == LIMIT) && id_pending;

    // Grant arbitration: L first unless the guard trips, then round-robin I/D; nothing during reset
    always_comb begin
        l_gnt = 1'b0;
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (l_req && !starve_hit) begin
                l_gnt = 1'b1;
            end else if (i_req && d_req) begin
                if (rr_ptr_q) begin
                    d_gnt = 1'b1;
                end else begin
                    i_gnt = 1'b1;
                end
            end else if (i_req) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Mux the granted port's address, write data and direction onto the single memory port
    always_comb begin
        acc_addr = i_addr;
        wr_data  = d_wdata;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        if (l_gnt) begin
            acc_addr = l_addr;
            wr_data  = l_wdata;
            wr_en    = l_we;
            rd_en    = !l_we;
        end else if (d_gnt) begin
            acc_addr = d_addr;
            wr_data  = d_wdata;
            wr_en    = d_we;
            rd_en    = !d_we;
        end else if (i_gnt) begin
            acc_addr = i_addr;
            rd_en    = 1'b1;
        end
    end

    // Next-state for round-robin pointer, starvation counter and read-return registers
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        l_rvalid_d   = l_gnt && !l_we;
        i_rvalid_d   = i_gnt;
        d_rvalid_d   = d_gnt && !d_we;
        rdata_d      = rdata_q;

        if (i_gnt) begin
            rr_ptr_d = 1'b1;
        end else if (d_gnt) begin
            rr_ptr_d = 1'b0;
        end

        if (!id_pending || i_gnt || d_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (l_gnt && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (rd_en) begin
            rdata_d = mem[acc_addr];
        end
    end

    // State and read-return registers; reset drops any access on a coinciding edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
            l_rvalid_q   <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            l_rvalid_q   <= l_rvalid_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory array write; contents are deliberately not reset, grants are already blocked in reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[acc_addr] <= wr_data;
        end
    end

    assign l_rvalid = l_rvalid_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter19.sv
// tb_mem_arbiter19: table-driven checks of grants, read returns and the
// starvation guard, plus a hand-written reset-in-the-middle-of-a-write sequence.
module tb_mem_arbiter19;

    localparam int DW = 19;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          l_req, i_req, d_req, l_we, d_we;
    logic [AW-1:0] l_addr, i_addr, d_addr;
    logic [DW-1:0] l_wdata, d_wdata;
    logic          l_gnt, i_gnt, d_gnt;
    logic          l_rvalid, i_rvalid, d_rvalid;
    logic [DW-1:0] rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          lr, lw;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic [2:0]    gnt;
        logic [2:0]    rv;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs[$];

    mem_arbiter19 #(.DW(DW), .AW(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .l_req(l_req), .i_req(i_req), .d_req(d_req),
        .l_we(l_we), .d_we(d_we),
        .l_addr(l_addr), .i_addr(i_addr), .d_addr(d_addr),
        .l_wdata(l_wdata), .d_wdata(d_wdata),
        .l_gnt(l_gnt), .i_gnt(i_gnt), .d_gnt(d_gnt),
        .l_rvalid(l_rvalid), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic lr, input logic lw, input int la, input int ld,
                                input logic ir, input int ia,
                                input logic dr, input logic dw, input int da, input int dd,
                                input logic [2:0] gnt, input logic [2:0] rv, input int rd);
        vec_t v;
        v.lr = lr; v.lw = lw; v.la = AW'(la); v.ld = DW'(ld);
        v.ir = ir; v.ia = AW'(ia);
        v.dr = dr; v.dw = dw; v.da = AW'(da); v.dd = DW'(dd);
        v.gnt = gnt; v.rv = rv; v.rd = DW'(rd);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        l_req = v.lr; l_we = v.lw; l_addr = v.la; l_wdata = v.ld;
        i_req = v.ir; i_addr = v.ia;
        d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Reset state with every request held high
        l_req = 1; i_req = 1; d_req = 1; l_we = 0; d_we = 0;
        l_addr = '0; i_addr = '0; d_addr = '0; l_wdata = '0; d_wdata = '0;
        #3;
        checkOutput("reset_gnt", {29'd0, l_gnt, i_gnt, d_gnt}, 32'd0);
        checkOutput("reset_rvalid", {29'd0, l_rvalid, i_rvalid, d_rvalid}, 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);

        // Loader fill of addresses 0..5, then program constants
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, 1, i, 'h2801a + i, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 0));
        vecs.push_back(mk(1, 1, 0, 'h0ce77, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 0));
        vecs.push_back(mk(1, 1, 40, 'h00123, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 0));
        vecs.push_back(mk(1, 1, 7, 'h00007, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000, 0));
        vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3'b100, 3'b100, 'h2801d));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 'h2801d));
        // Round-robin I/D
        for (int i = 0; i < 2; i++) begin
            vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 40, 0, 3'b010, 3'b010, 'h0ce77));
            vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 40, 0, 3'b001, 3'b001, 'h00123));
        end
        // Starvation guard: L,L,L,L,I twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                vecs.push_back(mk(1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 3'b100, 3'b100, 'h2801d));
            vecs.push_back(mk(1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 3'b010, 3'b010, 'h0ce77));
        end
        // Read-after-write at the top address, then address 0 untouched
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1023, 'h7ffff, 3'b001, 3'b000, 'h0ce77));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1023, 0, 0, 0, 0, 3'b010, 3'b010, 'h7ffff));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b001, 3'b001, 'h0ce77));
        // Lone I grant leaves rr_ptr pointing at D before the reset test
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b010, 3'b010, 'h0ce77));

        @(negedge clk);
        rst = 0;
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            #1;
            checkOutput($sformatf("gnt[%0d]", k), {29'd0, l_gnt, i_gnt, d_gnt}, 32'(vecs[k].gnt));
            @(posedge clk);
            #1;
            checkOutput($sformatf("rvalid[%0d]", k), {29'd0, l_rvalid, i_rvalid, d_rvalid}, 32'(vecs[k].rv));
            checkOutput($sformatf("rdata[%0d]", k), 32'(rdata), 32'(vecs[k].rd));
            @(negedge clk);
        end

        // Reset asserted during a granted D write to address 7
        l_req = 0; i_req = 0; d_req = 1; d_we = 1; d_addr = 10'd7; d_wdata = 19'h12345;
        #1;
        checkOutput("rst_pre_dgnt", {29'd0, l_gnt, i_gnt, d_gnt}, 32'b001);
        #1;
        rst = 1;
        #1;
        checkOutput("rst_gnt", {29'd0, l_gnt, i_gnt, d_gnt}, 32'd0);
        checkOutput("rst_rvalid", {29'd0, l_rvalid, i_rvalid, d_rvalid}, 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        @(posedge clk);
        #1;
        d_req = 0; d_we = 0;
        @(negedge clk);
        rst = 0;
        i_req = 1; i_addr = 10'd7; d_req = 1; d_addr = 10'd7;
        #1;
        checkOutput("post_rst_first_gnt", {29'd0, l_gnt, i_gnt, d_gnt}, 32'b010);
        @(posedge clk);
        #1;
        checkOutput("post_rst_i_rvalid", {29'd0, l_rvalid, i_rvalid, d_rvalid}, 32'b010);
        checkOutput("post_rst_mem7_i", 32'(rdata), 32'h00007);
        @(negedge clk);
        #1;
        checkOutput("post_rst_second_gnt", {29'd0, l_gnt, i_gnt, d_gnt}, 32'b001);
        @(posedge clk);
        #1;
        checkOutput("post_rst_d_rvalid", {29'd0, l_rvalid, i_rvalid, d_rvalid}, 32'b001);
        checkOutput("post_rst_mem7_d", 32'(rdata), 32'h00007);
        @(negedge clk);
        i_req = 0; d_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
